// File: rtl/ace_kbd_pkg.sv
// Shared types and constants for the PS/2 to Jupiter Ace keyboard front end:
// receiver states, prefix bytes, key indices and the scancode lookup.
package ace_kbd_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  localparam int NUM_KEYS = 52;
  localparam int KEY_W    = 6;

  // Indices 0..39 are matrix positions (row*5 + col); 40.. are keys that
  // drive more than one position or none at all.
  localparam logic [5:0] POS_SHIFT = 6'd0;
  localparam logic [5:0] POS_SYMSH = 6'd1;
  localparam logic [5:0] POS_5     = 6'd19;
  localparam logic [5:0] POS_0     = 6'd20;
  localparam logic [5:0] POS_8     = 6'd22;
  localparam logic [5:0] POS_7     = 6'd23;
  localparam logic [5:0] POS_6     = 6'd24;
  localparam logic [5:0] K_LSHIFT  = 6'd40;
  localparam logic [5:0] K_RSHIFT  = 6'd41;
  localparam logic [5:0] K_LCTRL   = 6'd42;
  localparam logic [5:0] K_RCTRL   = 6'd43;
  localparam logic [5:0] K_BKSP    = 6'd44;
  localparam logic [5:0] K_LEFT    = 6'd45;
  localparam logic [5:0] K_DOWN    = 6'd46;
  localparam logic [5:0] K_UP      = 6'd47;
  localparam logic [5:0] K_RIGHT   = 6'd48;
  localparam logic [5:0] K_LALT    = 6'd49;
  localparam logic [5:0] K_RALT    = 6'd50;
  localparam logic [5:0] K_DEL     = 6'd51;

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] idx;
  } key_t;

  function automatic key_t scancode_to_key(input logic ext, input logic [7:0] code);
    key_t k;
    k.valid = 1'b1;
    k.idx   = '0;
    if (!ext) begin
      case (code)
        8'h1A: k.idx = 6'd2;  8'h22: k.idx = 6'd3;  8'h21: k.idx = 6'd4;
        8'h1C: k.idx = 6'd5;  8'h1B: k.idx = 6'd6;  8'h23: k.idx = 6'd7;  8'h2B: k.idx = 6'd8;  8'h34: k.idx = 6'd9;
        8'h15: k.idx = 6'd10; 8'h1D: k.idx = 6'd11; 8'h24: k.idx = 6'd12; 8'h2D: k.idx = 6'd13; 8'h2C: k.idx = 6'd14;
        8'h16: k.idx = 6'd15; 8'h1E: k.idx = 6'd16; 8'h26: k.idx = 6'd17; 8'h25: k.idx = 6'd18; 8'h2E: k.idx = 6'd19;
        8'h45: k.idx = 6'd20; 8'h46: k.idx = 6'd21; 8'h3E: k.idx = 6'd22; 8'h3D: k.idx = 6'd23; 8'h36: k.idx = 6'd24;
        8'h4D: k.idx = 6'd25; 8'h44: k.idx = 6'd26; 8'h43: k.idx = 6'd27; 8'h3C: k.idx = 6'd28; 8'h35: k.idx = 6'd29;
        8'h5A: k.idx = 6'd30; 8'h4B: k.idx = 6'd31; 8'h42: k.idx = 6'd32; 8'h3B: k.idx = 6'd33; 8'h33: k.idx = 6'd34;
        8'h29: k.idx = 6'd35; 8'h3A: k.idx = 6'd36; 8'h31: k.idx = 6'd37; 8'h32: k.idx = 6'd38; 8'h2A: k.idx = 6'd39;
        8'h12: k.idx = K_LSHIFT; 8'h59: k.idx = K_RSHIFT; 8'h14: k.idx = K_LCTRL;
        8'h11: k.idx = K_LALT;   8'h66: k.idx = K_BKSP;
        default: k.valid = 1'b0;
      endcase
    end else begin
      case (code)
        8'h14: k.idx = K_RCTRL; 8'h11: k.idx = K_RALT; 8'h71: k.idx = K_DEL;
        8'h6B: k.idx = K_LEFT;  8'h72: k.idx = K_DOWN; 8'h75: k.idx = K_UP; 8'h74: k.idx = K_RIGHT;
        default: k.valid = 1'b0;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronises and deglitches both lines, then assembles
// 11-bit frames on filtered ps2clk falling edges, with an inter-edge watchdog.
module ps2_rx
  import ace_kbd_pkg::*;
#(
  parameter int CLK_HZ     = 6500000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic [7:0] code,
  output logic       strobe
);

  localparam int TIMEOUT_CYCLES = (CLK_HZ / 1000) * TIMEOUT_US / 1000;
  localparam int WD_W           = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            clk_sync, dat_sync;
  logic [FILTER_LEN-1:0] clk_hist, dat_hist;
  logic                  clk_f, dat_f, clk_f_q, fall;

  rx_state_t   state, state_n;
  logic [7:0]  shreg, shreg_n, code_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic        par, par_n, strobe_n;
  logic [WD_W-1:0] wd, wd_n;

  // Filtered levels only change after FILTER_LEN identical synchronised samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_hist <= '1;
      dat_hist <= '1;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_f_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      clk_sync <= {clk_sync[0], ps2clk};
      dat_sync <= {dat_sync[0], ps2dat};
      clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      dat_hist <= {dat_hist[FILTER_LEN-2:0], dat_sync[1]};
      if (&clk_hist) clk_f <= 1'b1; else if (~|clk_hist) clk_f <= 1'b0;
      if (&dat_hist) dat_f <= 1'b1; else if (~|dat_hist) dat_f <= 1'b0;
      clk_f_q  <= clk_f;
    end
  end

  assign fall = clk_f_q & ~clk_f;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RX_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      wd      <= '0;
      code    <= 8'h00;
      strobe  <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      par     <= par_n;
      wd      <= wd_n;
      code    <= code_n;
      strobe  <= strobe_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_n     = par;
    wd_n      = wd;
    code_n    = code;
    strobe_n  = 1'b0;
    if (state != RX_IDLE) wd_n = wd + 1'b1;
    if (fall) begin
      wd_n = '0;
      case (state)
        RX_IDLE: if (!dat_f) begin
          state_n   = RX_DATA;
          bit_cnt_n = '0;
        end
        RX_DATA: begin
          shreg_n   = {dat_f, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
        RX_PARITY: begin
          par_n   = dat_f;
          state_n = RX_STOP;
        end
        RX_STOP: begin
          state_n = RX_IDLE;
          if (dat_f && (^{shreg, par})) begin
            strobe_n = 1'b1;
            code_n   = shreg;
          end
        end
        default: state_n = RX_IDLE;
      endcase
    end else if (state != RX_IDLE && wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_n = RX_IDLE;
      wd_n    = '0;
    end
  end

endmodule

// File: rtl/ps2_ace_keyboard.sv
// Jupiter Ace keyboard front end: decodes PS/2 make/break codes into per-key
// press bits, folds them into the 8x5 matrix and serves the selected rows.
module ps2_ace_keyboard
  import ace_kbd_pkg::*;
#(
  parameter int CLK_HZ     = 6500000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2dat,
  input  logic [7:0] filas,
  output logic [4:0] columnas,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       user_reset
);

  logic                ext, brk;
  logic [NUM_KEYS-1:0] press;
  key_t                hit;
  logic [39:0]         matrix;
  logic [4:0]          col_hit;

  ps2_rx #(
    .CLK_HZ    (CLK_HZ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .clk   (clk),
    .reset (reset),
    .ps2clk(ps2clk),
    .ps2dat(ps2dat),
    .code  (key_code),
    .strobe(key_strobe)
  );

  assign hit = scancode_to_key(ext, key_code);

  // Compound keys share positions with plain keys, so a position is the OR of
  // every key that can drive it; releasing one never clobbers another.
  always_comb begin
    matrix            = press[39:0];
    matrix[POS_SHIFT] = press[K_LSHIFT] | press[K_RSHIFT] | press[K_BKSP]
                      | press[K_LEFT] | press[K_DOWN] | press[K_UP] | press[K_RIGHT];
    matrix[POS_SYMSH] = press[K_LCTRL] | press[K_RCTRL];
    matrix[POS_0]     = press[POS_0] | press[K_BKSP];
    matrix[POS_5]     = press[POS_5] | press[K_LEFT];
    matrix[POS_6]     = press[POS_6] | press[K_DOWN];
    matrix[POS_7]     = press[POS_7] | press[K_UP];
    matrix[POS_8]     = press[POS_8] | press[K_RIGHT];
  end

  always_comb begin
    col_hit = '0;
    for (int r = 0; r < 8; r++)
      if (!filas[r]) col_hit = col_hit | matrix[r*5 +: 5];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      press      <= '0;
      columnas   <= 5'b11111;
      user_reset <= 1'b0;
    end else begin
      columnas   <= ~col_hit;
      user_reset <= (press[K_LCTRL] | press[K_RCTRL]) & (press[K_LALT] | press[K_RALT])
                  & press[K_DEL];
      if (key_strobe) begin
        if (key_code == CODE_EXT) ext <= 1'b1;
        else if (key_code == CODE_BRK) brk <= 1'b1;
        else begin
          if (hit.valid) press[hit.idx] <= ~brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_ace_keyboard.sv
// Directed bench: PS/2 frames in, scoreboard of accepted scancodes checked by
// a monitor on key_strobe, plus direct column/user_reset checks.
module tb_ps2_ace_keyboard;

  localparam int HALF = 30;
  localparam int TIMEOUT_CYC = 13000;

  logic       clk = 1'b0;
  logic       reset, ps2clk, ps2dat;
  logic [7:0] filas;
  logic [4:0] columnas;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       user_reset;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_ace_keyboard dut (
    .clk       (clk),
    .reset     (reset),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .filas     (filas),
    .columnas  (columnas),
    .key_strobe(key_strobe),
    .key_code  (key_code),
    .user_reset(user_reset)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2dat = b;
    idle(HALF);
    ps2clk = 1'b0;
    idle(HALF);
    ps2clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit good = 1'b1);
    if (good) exp_q.push_back(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(good ? ~^b : ^b);
    ps2_bit(1'b1);
    ps2dat = 1'b1;
    idle(4 * HALF);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'b1);
  endtask

  task automatic cols(input string name, input logic [7:0] f, input logic [4:0] exp);
    filas = f;
    idle(4);
    check(name, {3'b000, columnas}, {3'b000, exp});
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (key_strobe) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_strobe: got %h expected none", key_code);
        end else begin
          check("key_code", key_code, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_columnas"}, {3'b000, columnas}, 8'h1F);
    check({tag, "_strobe"}, {7'b0, key_strobe}, 8'h00);
    check({tag, "_key_code"}, key_code, 8'h00);
    check({tag, "_user_reset"}, {7'b0, user_reset}, 8'h00);
  endtask

  initial begin
    reset  = 1'b1;
    ps2clk = 1'b1;
    ps2dat = 1'b1;
    filas  = 8'hFF;
    fork
      monitor();
    join_none
    idle(3);
    reset_values("rst");
    reset = 1'b0;
    idle(20);

    // A press/release in row 1
    filas = 8'hFD;
    send(8'h1C);
    cols("a_press", 8'hFD, 5'b11110);
    send(8'hF0); send(8'h1C);
    cols("a_release", 8'hFD, 5'b11111);

    // Shift + Z share row 0
    send(8'h12); send(8'h1A);
    cols("shift_z", 8'hFE, 5'b11010);
    cols("no_row", 8'hFF, 5'b11111);
    send(8'hF0); send(8'h12); send(8'hF0); send(8'h1A);
    cols("shift_z_rel", 8'hFE, 5'b11111);

    // Bad parity is dropped, the retry lands
    send(8'h29, 1'b0);
    cols("bad_parity", 8'h7F, 5'b11111);
    send(8'h29);
    cols("space", 8'h7F, 5'b11110);
    send(8'hF0); send(8'h29);

    // Stalled frame must be abandoned by the watchdog
    send_partial(5);
    ps2dat = 1'b1;
    idle(TIMEOUT_CYC + 200);
    send(8'h5A);
    cols("enter_after_to", 8'hBF, 5'b11110);
    send(8'hF0); send(8'h5A);

    // Backspace = Shift+0; releasing it keeps the plain 0
    send(8'h66);
    cols("bksp_shift", 8'hFE, 5'b11110);
    send(8'h45);
    send(8'hF0); send(8'h66);
    cols("zero_held", 8'hEF, 5'b11110);
    cols("shift_gone", 8'hFE, 5'b11111);
    send(8'hF0); send(8'h45);

    // Cursor left = Shift+5, two rows selected at once
    send(8'hE0); send(8'h6B);
    cols("left_5", 8'hF7, 5'b01111);
    cols("left_two_rows", 8'hF6, 5'b01110);
    send(8'hE0); send(8'hF0); send(8'h6B);
    cols("left_rel", 8'hF6, 5'b11111);

    // Ctrl+Alt+Del, then reset mid-frame
    send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
    cols("symshift", 8'hFE, 5'b11101);
    check("user_reset", {7'b0, user_reset}, 8'h01);
    send_partial(3);
    reset  = 1'b1;
    ps2dat = 1'b1;
    idle(2);
    reset_values("midrst");
    reset = 1'b0;
    idle(20);
    cols("released_after_rst", 8'hFE, 5'b11111);
    send(8'h1C);
    cols("a_after_rst", 8'hFD, 5'b11110);

    idle(50);
    check("pending_codes", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
